// File: rtl/pc_gen.sv
// Fetch-stage PC generator with optional direct-mapped BTB (enabled by PC_GEN_BTB_EN).
// Next PC: reset > freeze (!trigger) > redirect > stall > BTB prediction > PC+4.
module pc_gen #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'hBFC00000,
  parameter int                       BTB_ENTRIES   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic                     stall,
  input  logic                     ex_redirect,
  input  logic [ADDRESS_WIDTH-1:0] ex_redirect_pc,
  input  logic                     upd_en,
  input  logic [ADDRESS_WIDTH-1:0] upd_pc,
  input  logic [ADDRESS_WIDTH-1:0] upd_target,
  input  logic                     upd_taken,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4,
  output logic                     pred_taken,
  output logic [ADDRESS_WIDTH-1:0] pred_target
);

  logic [ADDRESS_WIDTH-1:0] r_pc;

  assign PC      = r_pc;
  assign PCPlus4 = r_pc + ADDRESS_WIDTH'(4);

`ifdef PC_GEN_BTB_EN
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;

  logic                     r_valid  [BTB_ENTRIES];
  logic [1:0]               r_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]         r_tag    [BTB_ENTRIES];
  logic [ADDRESS_WIDTH-1:0] r_target [BTB_ENTRIES];

  logic [IDX-1:0]   w_idx, w_uidx;
  logic [TAG_W-1:0] w_tag, w_utag;
  logic             w_hit, w_uhit, w_upd, w_unused;

  assign w_idx  = r_pc[IDX+1:2];
  assign w_tag  = r_pc[ADDRESS_WIDTH-1:IDX+2];
  assign w_uidx = upd_pc[IDX+1:2];
  assign w_utag = upd_pc[ADDRESS_WIDTH-1:IDX+2];
  assign w_unused = ^upd_pc[1:0];

  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_upd  = trigger && upd_en;

  assign pred_taken  = w_hit && r_ctr[w_idx][1];
  assign pred_target = pred_taken ? r_target[w_idx] : PCPlus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_uhit) begin
        if (upd_taken) begin
          if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
        end else if (r_ctr[w_uidx] != 2'b00) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset; the valid bit gates their use. On a hit the tag is unchanged.
  always_ff @(posedge clk) begin
    if (w_upd && upd_taken) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= upd_target;
    end
  end
`else
  logic w_unused;

  assign w_unused    = ^{upd_en, upd_pc, upd_target, upd_taken};
  assign pred_taken  = 1'b0;
  assign pred_target = PCPlus4;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else if (trigger) begin
      if (ex_redirect)  r_pc <= ex_redirect_pc;
      else if (!stall)  r_pc <= pred_target;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen against a table-based BTB reference model.
// Works in both builds; the model follows PC_GEN_BTB_EN.
module tb_pc_gen;
  localparam int          N   = 16;
  localparam int          IDX = $clog2(N);
  localparam logic [31:0] RV  = 32'hBFC00000;
`ifdef PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, trigger, stall, ex_redirect, upd_en, upd_taken;
  logic [31:0] ex_redirect_pc, upd_pc, upd_target;
  logic [31:0] PC, PCPlus4, pred_target;
  logic        pred_taken;

  pc_gen #(.ADDRESS_WIDTH(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .stall(stall),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .PC(PC), .PCPlus4(PCPlus4), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // Reference model: fetch PC plus a table of {valid, full upper tag, target, counter 0..3}
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          n_cmp = 0, n_err = 0;
  bit          e_taken;
  logic [31:0] e_tgt, p_save;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic void m_look(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i = ix(pc);
    t  = BTB_ON && m_valid[i] && (m_tag[i] == (pc >> (IDX + 2))) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc = RV;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic idle();
    trigger = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
    upd_en = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
  endtask

  // Advance model and DUT by one rising edge with the inputs currently driven.
  task automatic tick();
    bit          t;
    logic [31:0] tg, npc;
    int          i;
    m_look(m_pc, t, tg);
    npc = m_pc;
    if (trigger) begin
      if (ex_redirect) npc = ex_redirect_pc;
      else if (!stall) npc = tg;
      if (upd_en && BTB_ON) begin
        i = ix(upd_pc);
        if (m_valid[i] && m_tag[i] == (upd_pc >> (IDX + 2))) begin
          if (upd_taken) begin
            m_tgt[i] = upd_target;
            if (m_ctr[i] < 3) m_ctr[i]++;
          end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = upd_pc >> (IDX + 2);
          m_tgt[i]   = upd_target;
          m_ctr[i]   = 2;
        end
      end
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    upd_en = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    ex_redirect = 1'b1; ex_redirect_pc = pc;
    tick();
    ex_redirect = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m_reset();
    #12 rst = 1'b0;
    n_cmp++; if (PC !== RV) begin n_err++; $display("FAIL reset_pc got %h exp %h", PC, RV); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'hBFC00004) begin n_err++; $display("FAIL reset_tgt got %h exp BFC00004", pred_target); end
    tick();
    n_cmp++; if (PC !== 32'hBFC00004) begin n_err++; $display("FAIL seq1 got %h exp BFC00004", PC); end
    tick();
    n_cmp++; if (PC !== 32'hBFC00008) begin n_err++; $display("FAIL seq2 got %h exp BFC00008", PC); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (PC !== RV) begin n_err++; $display("FAIL async_rst_pc got %h exp %h", PC, RV); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL async_rst_pred got %b exp 0", pred_taken); end
    #1 rst = 1'b0;
    m_reset();
    tick();
    n_cmp++; if (PC !== 32'hBFC00004) begin n_err++; $display("FAIL post_rst got %h exp BFC00004", PC); end
  endtask

  task automatic test_alloc_predict();
    do_update(32'hBFC00010, 32'hBFC00100, 1'b1);
    do_redirect(32'hBFC00010);
    m_look(m_pc, e_taken, e_tgt);
    n_cmp++; if (PC !== 32'hBFC00010) begin n_err++; $display("FAIL alloc_pc got %h exp BFC00010", PC); end
    n_cmp++; if (pred_taken !== e_taken) begin n_err++; $display("FAIL alloc_pred got %b exp %b", pred_taken, e_taken); end
    n_cmp++; if (pred_target !== e_tgt) begin n_err++; $display("FAIL alloc_tgt got %h exp %h", pred_target, e_tgt); end
    tick();
    n_cmp++; if (PC !== m_pc) begin n_err++; $display("FAIL alloc_next got %h exp %h", PC, m_pc); end
  endtask

  task automatic test_counter();
    do_update(32'hBFC00010, 32'hBFC00100, 1'b0);
    do_update(32'hBFC00010, 32'hBFC00100, 1'b0);
    do_redirect(32'hBFC00010);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_weak_pred got %b exp 0", pred_taken); end
    tick();
    n_cmp++; if (PC !== 32'hBFC00014) begin n_err++; $display("FAIL ctr_fall got %h exp BFC00014", PC); end
    for (int k = 0; k < 3; k++) do_update(32'hBFC00010, 32'hBFC00180, 1'b1);
    do_update(32'hBFC00010, 32'hBFC00180, 1'b0);
    do_redirect(32'hBFC00010);
    m_look(m_pc, e_taken, e_tgt);
    n_cmp++; if (pred_taken !== e_taken) begin n_err++; $display("FAIL ctr_sat_pred got %b exp %b", pred_taken, e_taken); end
    tick();
    n_cmp++; if (PC !== m_pc) begin n_err++; $display("FAIL ctr_sat_next got %h exp %h", PC, m_pc); end
  endtask

  task automatic test_priority();
    stall = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h00001000;
    tick();
    ex_redirect = 1'b0;
    n_cmp++; if (PC !== 32'h00001000) begin n_err++; $display("FAIL redir_over_stall got %h exp 00001000", PC); end
    tick(); tick();
    n_cmp++; if (PC !== 32'h00001000) begin n_err++; $display("FAIL stall_hold got %h exp 00001000", PC); end
    stall = 1'b0;
    tick();
    n_cmp++; if (PC !== 32'h00001004) begin n_err++; $display("FAIL stall_release got %h exp 00001004", PC); end
  endtask

  task automatic test_freeze();
    p_save = m_pc;
    trigger = 1'b0;
    upd_en = 1'b1; upd_pc = 32'hBFC00200; upd_target = 32'hBFC00300; upd_taken = 1'b1;
    ex_redirect = 1'b1; ex_redirect_pc = 32'h00002000;
    tick(); tick();
    n_cmp++; if (PC !== p_save) begin n_err++; $display("FAIL freeze_pc got %h exp %h", PC, p_save); end
    idle();
    do_redirect(32'hBFC00200);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL freeze_btb got %b exp 0", pred_taken); end
    tick();
    n_cmp++; if (PC !== 32'hBFC00204) begin n_err++; $display("FAIL freeze_next got %h exp BFC00204", PC); end
  endtask

  task automatic test_alias_wrap();
    do_update(32'hBFC00010, 32'hBFC00100, 1'b1);
    do_update(32'hBFC00050, 32'hBFC00500, 1'b1);
    do_redirect(32'hBFC00010);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_evict got %b exp 0", pred_taken); end
    tick();
    n_cmp++; if (PC !== 32'hBFC00014) begin n_err++; $display("FAIL alias_next got %h exp BFC00014", PC); end
    do_redirect(32'hBFC00050);
    m_look(m_pc, e_taken, e_tgt);
    n_cmp++; if (pred_taken !== e_taken) begin n_err++; $display("FAIL alias_new got %b exp %b", pred_taken, e_taken); end
    n_cmp++; if (pred_target !== e_tgt) begin n_err++; $display("FAIL alias_tgt got %h exp %h", pred_target, e_tgt); end
    do_redirect(32'hFFFFFFFC);
    n_cmp++; if (PCPlus4 !== 32'h00000000) begin n_err++; $display("FAIL wrap_plus4 got %h exp 00000000", PCPlus4); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL wrap_pred got %b exp 0", pred_taken); end
    tick();
    n_cmp++; if (PC !== 32'h00000000) begin n_err++; $display("FAIL wrap_pc got %h exp 00000000", PC); end
  endtask

  task automatic test_same_cycle();
    do_redirect(32'hBFC00300);
    upd_en = 1'b1; upd_pc = 32'hBFC00300; upd_target = 32'hBFC00800; upd_taken = 1'b1;
    tick();
    upd_en = 1'b0;
    n_cmp++; if (PC !== 32'hBFC00304) begin n_err++; $display("FAIL same_cycle_old got %h exp BFC00304", PC); end
    do_redirect(32'hBFC00300);
    tick();
    n_cmp++; if (PC !== m_pc) begin n_err++; $display("FAIL same_cycle_new got %h exp %h", PC, m_pc); end
  endtask

  function automatic logic [31:0] rpc();
    return RV + (32'($urandom_range(47, 0)) << 2);
  endfunction

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      trigger        = ($urandom_range(99, 0) < 90);
      stall          = ($urandom_range(99, 0) < 20);
      ex_redirect    = ($urandom_range(99, 0) < 12);
      ex_redirect_pc = rpc();
      upd_en         = ($urandom_range(99, 0) < 40);
      upd_pc         = rpc();
      upd_target     = rpc();
      upd_taken      = ($urandom_range(99, 0) < 60);
      m_look(m_pc, e_taken, e_tgt);
      n_cmp++; if (PC !== m_pc) begin n_err++; $display("FAIL rnd_pc k=%0d got %h exp %h", k, PC, m_pc); end
      n_cmp++; if (PCPlus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_plus4 k=%0d got %h exp %h", k, PCPlus4, m_pc + 32'd4); end
      n_cmp++; if (pred_taken !== e_taken) begin n_err++; $display("FAIL rnd_pred k=%0d got %b exp %b", k, pred_taken, e_taken); end
      n_cmp++; if (pred_target !== e_tgt) begin n_err++; $display("FAIL rnd_tgt k=%0d got %h exp %h", k, pred_target, e_tgt); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midrun();
    do_update(32'hBFC00020, 32'hBFC00400, 1'b1);
    do_redirect(32'hBFC00020);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (PC !== RV) begin n_err++; $display("FAIL midrun_rst_pc got %h exp %h", PC, RV); end
    n_cmp++; if (pred_target !== 32'hBFC00004) begin n_err++; $display("FAIL midrun_rst_tgt got %h exp BFC00004", pred_target); end
    #1 rst = 1'b0;
    m_reset();
    do_redirect(32'hBFC00020);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL midrun_rst_btb got %b exp 0", pred_taken); end
  endtask

  initial begin
    test_reset();
    test_alloc_predict();
    test_counter();
    test_priority();
    test_freeze();
    test_alias_wrap();
    test_same_cycle();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
